// File: rtl/gfx_pkg.sv
// gfx shared package: mailbox register offsets,
// status bit positions and status word layout.
package gfx_pkg;

  localparam logic [31:0] GFX_MBOX_STATUS   = 32'h0;
  localparam logic [31:0] GFX_MBOX_CMD_POP  = 32'h4;
  localparam logic [31:0] GFX_MBOX_REPLY    = 32'h8;
  localparam logic [31:0] GFX_MBOX_IRQ_CTRL = 32'hC;

  localparam int GFX_ST_CMD_EMPTY  = 16;
  localparam int GFX_ST_REPLY_FULL = 17;
  localparam int GFX_ST_POP_UNF    = 18;
  localparam int GFX_ST_REPLY_OVF  = 19;

  typedef struct packed {
    logic [11:0] rsvd;
    logic        reply_ovf;
    logic        pop_unf;
    logic        reply_full;
    logic        cmd_empty;
    logic [15:0] cmd_count;
  } gfx_mbox_status_t;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } gfx_wr_st_e;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } gfx_rd_st_e;

  function automatic logic [1:0] gfx_reg_idx(
    input logic [31:0] off
  );
    return off[3:2];
  endfunction

endpackage

// File: rtl/gfx_axil.sv
// gfx_axil: AXI-lite bundle without strobes or resp.
// Slave and master views via modports.
interface gfx_axil;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport s (
    input  awvalid, awaddr, wvalid, wdata,
    input  bready, arvalid, araddr, rready,
    output awready, wready, bvalid,
    output arready, rvalid, rdata
  );

  modport m (
    output awvalid, awaddr, wvalid, wdata,
    output bready, arvalid, araddr, rready,
    input  awready, wready, bvalid,
    input  arready, rvalid, rdata
  );
endinterface

// File: rtl/gfx_fifo.sv
// gfx_fifo: synchronous show-ahead FIFO.
// Push is accepted when full only alongside a pop.
module gfx_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // storage write, contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally, count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/gfx_sched_mailbox.sv
// gfx_sched_mailbox: host/scheduler command and
// reply mailbox behind an AXI-lite slave port.
module gfx_sched_mailbox
  import gfx_pkg::*;
#(
  parameter int CMD_DEPTH   = 16,
  parameter int REPLY_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  gfx_axil.s          axis,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  output logic        reply_valid,
  input  logic        reply_ready,
  output logic [31:0] reply_data,
  output logic        irq_cmd
);

  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int RCW = $clog2(REPLY_DEPTH) + 1;

  gfx_wr_st_e       wr_st;
  gfx_rd_st_e       rd_st;
  gfx_mbox_status_t status;
  logic             alive;
  logic             irq_en;
  logic             pop_unf;
  logic             reply_ovf;
  logic [31:0]      rdata_q;
  logic [31:0]      rdata_nxt;
  logic             cmd_full;
  logic             cmd_empty;
  logic [CCW-1:0]   cmd_count;
  logic [CCW-1:0]   cmd_count_nxt;
  logic [31:0]      cmd_head;
  logic             reply_full;
  logic             reply_empty;
  logic [RCW-1:0]   reply_count;
  logic [1:0]       wsel;
  logic [1:0]       rsel;
  logic             wr_fire;
  logic             rd_fire;
  logic             cmd_push;
  logic             cmd_pop_req;
  logic             cmd_pop;
  logic             reply_push;
  logic             reply_pop;
  logic             unf_set;
  logic             ovf_set;
  logic             irq_wr;
  logic             st_clr;
  logic             irq_en_nxt;
  logic             unused_ok;

  assign wsel = axis.awaddr[3:2];
  assign rsel = axis.araddr[3:2];

  // alive keeps every AXI ready low during reset
  assign wr_fire = alive & axis.awvalid
                 & axis.wvalid
                 & (wr_st == WR_IDLE);
  assign axis.awready = wr_fire;
  assign axis.wready  = wr_fire;
  assign axis.bvalid  = (wr_st == WR_RESP);
  assign axis.arready = alive & (rd_st == RD_IDLE);
  assign axis.rvalid  = (rd_st == RD_RESP);
  assign axis.rdata   = rdata_q;
  assign rd_fire = axis.arvalid & axis.arready;

  assign cmd_ready   = ~cmd_full;
  assign cmd_push    = cmd_valid & cmd_ready;
  assign cmd_pop_req = rd_fire
    & (rsel == gfx_reg_idx(GFX_MBOX_CMD_POP));
  assign cmd_pop = cmd_pop_req & ~cmd_empty;
  assign unf_set = cmd_pop_req & cmd_empty;

  assign reply_valid = ~reply_empty;
  assign reply_pop   = reply_valid & reply_ready;
  assign reply_push  = wr_fire
    & (wsel == gfx_reg_idx(GFX_MBOX_REPLY));
  assign ovf_set = reply_push & reply_full
                 & ~reply_pop;

  assign irq_wr = wr_fire
    & (wsel == gfx_reg_idx(GFX_MBOX_IRQ_CTRL));
  assign st_clr     = irq_wr & axis.wdata[1];
  assign irq_en_nxt = irq_wr ? axis.wdata[0]
                             : irq_en;
  assign cmd_count_nxt = cmd_count
                       + CCW'(cmd_push)
                       - CCW'(cmd_pop);

  assign unused_ok = ^{axis.awaddr[31:4],
                       axis.awaddr[1:0],
                       axis.araddr[31:4],
                       axis.araddr[1:0],
                       reply_count};

  gfx_fifo #(
    .WIDTH (32),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .din   (cmd_data),
    .pop   (cmd_pop),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  gfx_fifo #(
    .WIDTH (32),
    .DEPTH (REPLY_DEPTH)
  ) u_reply_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (reply_push),
    .din   (axis.wdata),
    .pop   (reply_pop),
    .dout  (reply_data),
    .full  (reply_full),
    .empty (reply_empty),
    .count (reply_count)
  );

  // live status word as seen by a STATUS read
  always_comb begin
    status            = '0;
    status.cmd_count  = 16'(cmd_count);
    status.cmd_empty  = cmd_empty;
    status.reply_full = reply_full;
    status.pop_unf    = pop_unf;
    status.reply_ovf  = reply_ovf;
  end

  // read mux, sampled at the AR handshake
  always_comb begin
    rdata_nxt = '0;
    unique case (1'b1)
      rsel == gfx_reg_idx(GFX_MBOX_STATUS):
        rdata_nxt = status;
      rsel == gfx_reg_idx(GFX_MBOX_CMD_POP):
        rdata_nxt = cmd_empty ? '0 : cmd_head;
      rsel == gfx_reg_idx(GFX_MBOX_IRQ_CTRL):
        rdata_nxt = {31'b0, irq_en};
      default:
        rdata_nxt = '0;
    endcase
  end

  // AXI FSMs, control registers and the irq level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive     <= 1'b0;
      wr_st     <= WR_IDLE;
      rd_st     <= RD_IDLE;
      rdata_q   <= '0;
      irq_en    <= 1'b0;
      pop_unf   <= 1'b0;
      reply_ovf <= 1'b0;
      irq_cmd   <= 1'b0;
    end else begin
      alive <= 1'b1;
      unique case (wr_st)
        WR_IDLE: if (wr_fire)     wr_st <= WR_RESP;
        WR_RESP: if (axis.bready) wr_st <= WR_IDLE;
        default:                  wr_st <= WR_IDLE;
      endcase
      unique case (rd_st)
        RD_IDLE: if (rd_fire) begin
          rd_st   <= RD_RESP;
          rdata_q <= rdata_nxt;
        end
        RD_RESP: if (axis.rready) rd_st <= RD_IDLE;
        default:                  rd_st <= RD_IDLE;
      endcase
      irq_en <= irq_en_nxt;
      if (unf_set)     pop_unf <= 1'b1;
      else if (st_clr) pop_unf <= 1'b0;
      if (ovf_set)     reply_ovf <= 1'b1;
      else if (st_clr) reply_ovf <= 1'b0;
      irq_cmd <= irq_en_nxt & (cmd_count_nxt != '0);
    end
  end

endmodule

// File: tb/tb_gfx_sched_mailbox.sv
// tb_gfx_sched_mailbox: directed stimulus with a
// queue scoreboard checked by negedge monitors.
module tb_gfx_sched_mailbox;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_data = '0;
  logic        reply_valid;
  logic        reply_ready = 1'b0;
  logic [31:0] reply_data;
  logic        irq_cmd;

  int checks = 0;
  int errors = 0;
  int pend_b = 0;
  logic [31:0] exp_r[$];
  logic [31:0] exp_rep[$];

  gfx_axil axi ();

  gfx_sched_mailbox #(
    .CMD_DEPTH   (16),
    .REPLY_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axis        (axi),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .reply_valid (reply_valid),
    .reply_ready (reply_ready),
    .reply_data  (reply_data),
    .irq_cmd     (irq_cmd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic tmo(input string n);
    checks++;
    errors++;
    $display("FAIL timeout %s: got none want event", n);
  endtask

  // response monitors
  always @(negedge clk) begin
    if (rst_n && axi.rvalid && axi.rready) begin
      if (exp_r.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_extra: got %h want none",
                 axi.rdata);
      end else chk("rdata", axi.rdata, exp_r.pop_front());
    end
    if (rst_n && axi.bvalid && axi.bready) begin
      if (pend_b == 0) begin
        checks++; errors++;
        $display("FAIL b_extra: got bvalid want none");
      end else pend_b--;
    end
    if (rst_n && reply_valid && reply_ready) begin
      if (exp_rep.size() == 0) begin
        checks++; errors++;
        $display("FAIL reply_extra: got %h want none",
                 reply_data);
      end else chk("reply", reply_data, exp_rep.pop_front());
    end
  end

  task automatic wait_ar();
    int n = 0;
    @(negedge clk);
    while (!axi.arready) begin
      if (++n > 100) begin tmo("arready"); return; end
      @(negedge clk);
    end
  endtask

  task automatic wait_aw();
    int n = 0;
    @(negedge clk);
    while (!axi.awready) begin
      if (++n > 100) begin tmo("awready"); return; end
      @(negedge clk);
    end
  endtask

  task automatic wait_cmd_rdy();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready) begin
      if (++n > 100) begin tmo("cmd_ready"); return; end
      @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while (exp_r.size() != 0 || pend_b != 0
           || (reply_ready && exp_rep.size() != 0)) begin
      if (++n > 100) begin tmo("drain"); return; end
      @(negedge clk);
    end
  endtask

  task automatic axi_read(input logic [31:0] a,
                          input logic [31:0] e);
    exp_r.push_back(e);
    @(posedge clk); #1;
    axi.arvalid = 1'b1;
    axi.araddr  = a;
    wait_ar();
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    wait_drain();
  endtask

  task automatic axi_write(input logic [31:0] a,
                           input logic [31:0] d);
    pend_b++;
    @(posedge clk); #1;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    axi.awaddr  = a;
    axi.wdata   = d;
    wait_aw();
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    wait_drain();
  endtask

  task automatic push_cmd(input logic [31:0] d);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_data  = d;
    wait_cmd_rdy();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.awaddr  = '0;
    axi.wdata   = '0;
    axi.bready  = 1'b1;
    axi.arvalid = 1'b0;
    axi.araddr  = '0;
    axi.rready  = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", axi.arready, 0);
    chk("rst_awready", axi.awready, 0);
    chk("rst_wready", axi.wready, 0);
    chk("rst_bvalid", axi.bvalid, 0);
    chk("rst_rvalid", axi.rvalid, 0);
    chk("rst_irq", irq_cmd, 0);
    chk("rst_reply_valid", reply_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // three host words, irq masked
    push_cmd(32'hA000_000A);
    push_cmd(32'hB000_000B);
    push_cmd(32'hC000_000C);
    axi_read(32'h0, 32'h0000_0003);
    chk("irq_masked", irq_cmd, 0);

    // enable irq: one cycle after the write beat
    pend_b++;
    @(posedge clk); #1;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    axi.awaddr = 32'hC; axi.wdata = 32'h1;
    wait_aw();
    chk("irq_before_edge", irq_cmd, 0);
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    chk("irq_enabled", irq_cmd, 1);
    wait_drain();

    axi_read(32'h4, 32'hA000_000A);
    axi_read(32'h4, 32'hB000_000B);
    chk("irq_still", irq_cmd, 1);
    axi_read(32'h4, 32'hC000_000C);
    chk("irq_empty", irq_cmd, 0);

    // underflow sticky and clear
    axi_read(32'h4, 32'h0);
    axi_read(32'h0, 32'h0005_0000);
    axi_write(32'hC, 32'h3);
    axi_read(32'h0, 32'h0001_0000);
    axi_read(32'hC, 32'h1);

    // reply overflow: ninth word dropped
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_rep.push_back(32'h5EB0_0000 + i);
      axi_write(32'h8, 32'h5EB0_0000 + i);
    end
    axi_read(32'h0, 32'h000B_0000);
    axi_read(32'h8, 32'h0);
    chk("reply_head", reply_data, 32'h5EB0_0000);
    @(posedge clk); #1;
    reply_ready = 1'b1;
    wait_drain();
    chk("reply_drained", reply_valid, 0);
    @(posedge clk); #1;
    reply_ready = 1'b0;

    // read stall with a second AR waiting
    axi.rready = 1'b0;
    exp_r.push_back(32'h0009_0000);
    exp_r.push_back(32'h0);
    @(posedge clk); #1;
    axi.arvalid = 1'b1; axi.araddr = 32'h0;
    wait_ar();
    @(posedge clk); #1;
    axi.araddr = 32'h4;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_rvalid", axi.rvalid, 1);
      chk("stall_rdata", axi.rdata, 32'h0009_0000);
      chk("stall_arready", axi.arready, 0);
    end
    @(posedge clk); #1;
    axi.rready = 1'b1;
    wait_ar();
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    wait_drain();

    // write stall with a second write waiting
    axi.bready = 1'b0;
    pend_b += 2;
    @(posedge clk); #1;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    axi.awaddr = 32'hC; axi.wdata = 32'h3;
    wait_aw();
    @(posedge clk); #1;
    axi.wdata = 32'h1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_bvalid", axi.bvalid, 1);
      chk("stall_awready", axi.awready, 0);
    end
    @(posedge clk); #1;
    axi.bready = 1'b1;
    wait_aw();
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    wait_drain();
    axi_read(32'h0, 32'h0001_0000);
    axi_read(32'hC, 32'h1);

    // fill CMD, then exchange at full
    for (int i = 0; i < 16; i++)
      push_cmd(32'hD000_0000 + i);
    @(negedge clk);
    chk("full_ready", cmd_ready, 0);
    chk("full_irq", irq_cmd, 1);
    axi_read(32'h0, 32'h0000_0010);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_data = 32'hE000_0000;
    axi_read(32'h4, 32'hD000_0000);
    begin
      int n = 0;
      @(negedge clk);
      while (cmd_ready) begin
        if (++n > 100) begin tmo("refill"); break; end
        @(negedge clk);
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    axi_read(32'h0, 32'h0000_0010);

    // same-cycle push and pop at 15 entries
    axi_read(32'h4, 32'hD000_0001);
    exp_r.push_back(32'hD000_0002);
    @(posedge clk); #1;
    axi.arvalid = 1'b1; axi.araddr = 32'h4;
    cmd_valid = 1'b1; cmd_data = 32'hE000_0001;
    @(negedge clk);
    chk("sim_arready", axi.arready, 1);
    chk("sim_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    cmd_valid = 1'b0;
    wait_drain();
    axi_read(32'h0, 32'h0000_000F);

    for (int i = 3; i < 16; i++)
      axi_read(32'h4, 32'hD000_0000 + i);
    axi_read(32'h4, 32'hE000_0000);
    axi_read(32'h4, 32'hE000_0001);
    axi_read(32'h0, 32'h0001_0000);
    chk("final_irq", irq_cmd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
